fifo_arbiter: RTL and testbench
===============================

# fifo_arbiter

Write-side arbiter and read sequencer for the shared 16x16 `fifo`. Two producers compete for the FIFO write port under burst-limited round-robin, and one consumer issues read requests. The block keeps its own authoritative occupancy count and gates all FIFO `write`/`read` strobes with it; FIFO flag outputs are not used. It sits between the producer/consumer logic and the `fifo` instance, and drives that instance's `write`, `read` and `fifo_in` inputs.

## Interface
- `WIDTH`, 16: data width; must match the FIFO.
- `DEPTH`, 16: usable FIFO entries; the count saturates here.
- `BURST`, 4: max consecutive accepts for one owner while the other producer is requesting; ≥1.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0`, `req1`  in  1  producer N has data valid.
- `data0`, `data1`  in  WIDTH  producer N data; held stable while `reqN` is high and `ackN` is low.
- `ack0`, `ack1`  out  1  combinational accept. A transfer occurs at a clock edge where `reqN & ackN`.
- `rd_req`  in  1  consumer wants one word.
- `rd_ack`  out  1  combinational read accept (`rd_req & ~empty`).
- `rd_valid`  out  1  registered; FIFO output word is valid this cycle.
- `fifo_write`  out  1  registered; drives FIFO `write`.
- `fifo_in`  out  WIDTH  registered; drives FIFO `fifo_in`.
- `fifo_read`  out  1  registered; drives FIFO `read`.
- `full`, `empty`  out  1  `count==DEPTH`, `count==0`.
- `owner`  out  1  last accepted producer.

## Operation
- **State machine** `IDLE`, `OWN0`, `OWN1`. Also holds `burst_cnt` (0..BURST), `last` (1 bit) and `count` (0..DEPTH, `$clog2(DEPTH+1)` bits).
- **Accept rule** (evaluated only when `~full`; at most one `ackN` per cycle):
  - In `OWNx`: accept x if `reqx & ~(burst_cnt==BURST & req_other)`. Otherwise accept the other producer if it is requesting.
  - In `IDLE`: accept the producer that is not `last`; if it is idle, accept the one that is requesting.
- **Transitions:**
  - Accepting x moves to `OWNx`. `burst_cnt` becomes `burst_cnt+1` if x equals the previous owner, otherwise 1. `last`/`owner` become x.
  - If `full`, nothing is accepted and state holds.
  - If neither producer requests, go to `IDLE` with `burst_cnt=0`.
- **Write issue:** an accept at edge k registers `fifo_write=1` and `fifo_in=dataN` for the cycle after k. Otherwise `fifo_write=0`, and `fifo_in` holds its last value.
- **Read issue:** `rd_ack` at edge k registers `fifo_read=1` for the cycle after k. `rd_valid` goes high one cycle after `fifo_read`.
- **Count:**
  - Increments on a write accept and decrements on `rd_ack`.
  - When both happen in the same edge, count is unchanged. Both accepts are allowed when `0<count<DEPTH`.
  - When `count==0`, reads are blocked and the write proceeds.
  - When `count==DEPTH`, writes are blocked and the read proceeds, so the count drops to DEPTH-1.
  - Count never wraps. An accept past a bound is impossible by construction, and any attempt is a verification error.
- **Reset** (synchronous):
  - Outputs: `ack*`, `rd_ack` and `rd_valid` = 0; `fifo_write`, `fifo_read` and `fifo_in` = 0; `owner` = 0; `full` = 0; `empty` = 1.
  - Internal: state `IDLE`, `count` = 0, `burst_cnt` = 0, `last` = 1, so `req0` wins the first tie.
- **Reset mid-operation:** pending registered strobes are cleared at that edge; no write or read is issued in the following cycle. The FIFO must be reset in the same cycle.

## Timing
- Producer accept to `fifo_write`: 1 cycle.
- FIFO captures the word at the next edge, i.e. 2 edges after the accept.
- `rd_req` accept to `fifo_read`: 1 cycle. `fifo_read` to `rd_valid`/data: 1 cycle.
- Throughput: one write and one read per cycle.
- A word accepted at edge k can be read-accepted at edge k+1. Its `fifo_read` then falls after the FIFO write edge, so ordering is safe.
- Flags are registered count decodes; they reflect the count after the edge.

## Configuration
- `FIFO_ARB_STATS_EN` defined adds three outputs, each cleared by `reset`:
  - `grant_cnt0`, 16-bit, saturating: counts accepts for producer 0.
  - `grant_cnt1`, 16-bit, saturating: counts accepts for producer 1.
  - `stall_cnt`, 16-bit, saturating: counts cycles with `(req0|req1) & full`.
- Undefined: these ports and counters are absent; arbitration behaviour is identical.

## Structure
- Package `fifo_arb_pkg`: state encoding (`IDLE`, `OWN0`, `OWN1`), default `WIDTH`/`DEPTH`/`BURST` constants, and the stats counter width.
- Sub-module `fifo_arb_occupancy`: the count register with inc/dec inputs and `full`/`empty` decode. Everything else stays in `fifo_arbiter`.

## Test plan
- **Reset, then single producer:** reset, then `req0` held with data 0x0001..0x0005 → `ack0` on 5 consecutive edges, `fifo_write` one cycle later each, count=5, `empty`=0.
- **Contention with BURST=4:** `req0` and `req1` both held → accept order 0,0,0,0,1,1,1,1,0…; `owner` toggles every 4 accepts.
- **Fill to full:** 16 writes with no reads → `full`=1, `ack0`=`ack1`=0 while `req` stays high. One `rd_req` → `rd_ack`; count becomes 15 and accepts resume the next cycle.
- **Empty boundary:** count=0, `rd_req` and `req1` in the same cycle → `rd_ack`=0, write accepted, count=1. Next cycle `rd_ack`=1 and `rd_valid` 2 cycles later with the written word.
- **Steady stream:** count=8, simultaneous accept and `rd_ack` for 10 cycles → count stays 8, with one `fifo_write` and one `fifo_read` per cycle.
- **Reset mid-burst:** `reset` during a burst → `fifo_write`=0 the next cycle, count=0, state `IDLE`. With `FIFO_ARB_STATS_EN`, all stats read 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and default sizes for the fifo write arbiter
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_BURST = 4;
  localparam int STAT_W    = 16;
endpackage

// File: rtl/fifo_arb_occupancy.sv
// fifo_arb_occupancy: authoritative fifo occupancy count with full/empty decode
module fifo_arb_occupancy import fifo_arb_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);
  logic [CW-1:0] count_d, count_q;
  // simultaneous inc and dec cancel; callers never push past a bound
  always_comb count_d = (inc & ~dec) ? count_q + CW'(1) : (dec & ~inc) ? count_q - CW'(1) : count_q;
  // count register
  always_ff @(posedge clock) count_q <= reset ? '0 : count_d;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: burst-limited round-robin write arbiter and read sequencer for a shared fifo (optional stats via FIFO_ARB_STATS_EN)
module fifo_arbiter import fifo_arb_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BURST = DEF_BURST
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             rd_req,
  output logic             ack0,
  output logic             ack1,
  output logic             rd_ack,
  output logic             rd_valid,
  output logic             fifo_write,
  output logic [WIDTH-1:0] fifo_in,
  output logic             fifo_read,
  output logic             full,
  output logic             empty,
  output logic             owner
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1,
  output logic [STAT_W-1:0] stall_cnt
`endif
);
  localparam int BW = $clog2(BURST + 1);
  state_e           state_d, state_q;
  logic [BW-1:0]    burst_d, burst_q;
  logic             last_d, last_q, owner_d, owner_q;
  logic             fifo_write_d, fifo_write_q, fifo_read_d, fifo_read_q, rd_valid_d, rd_valid_q;
  logic [WIDTH-1:0] fifo_in_d, fifo_in_q;
  logic             bmax, pref1, en, acc;
  fifo_arb_occupancy #(.DEPTH(DEPTH)) u_occ (
    .clock(clock),
    .reset(reset),
    .inc  (acc),
    .dec  (rd_ack),
    .full (full),
    .empty(empty)
  );
  // arbitration: pref1 says producer 1 wins when both request; burst limit hands over ownership
  always_comb begin
    bmax         = burst_q == BW'(BURST);
    pref1        = state_q == OWN1 ? ~(bmax & req0) : state_q == OWN0 ? (bmax & req1) : ~last_q;
    en           = ~reset & ~full;
    ack1         = en & req1 & (pref1 | ~req0);
    ack0         = en & req0 & ~ack1;
    acc          = ack0 | ack1;
    rd_ack       = ~reset & rd_req & ~empty;
    state_d      = acc ? (ack1 ? OWN1 : OWN0) : (~req0 & ~req1) ? IDLE : state_q;
    burst_d      = acc ? ((ack1 == last_q) ? (bmax ? burst_q : burst_q + BW'(1)) : BW'(1))
                       : (~req0 & ~req1) ? '0 : burst_q;
    last_d       = acc ? ack1 : last_q;
    owner_d      = acc ? ack1 : owner_q;
    fifo_write_d = acc;
    fifo_in_d    = ack0 ? data0 : ack1 ? data1 : fifo_in_q;
    fifo_read_d  = rd_ack;
    rd_valid_d   = fifo_read_q;
  end
  // arbiter state and registered fifo strobes; reset clears any pending strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_q      <= '0;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      fifo_write_q <= 1'b0;
      fifo_in_q    <= '0;
      fifo_read_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      fifo_write_q <= fifo_write_d;
      fifo_in_q    <= fifo_in_d;
      fifo_read_q  <= fifo_read_d;
      rd_valid_q   <= rd_valid_d;
    end
  end
  assign fifo_write = fifo_write_q;
  assign fifo_in    = fifo_in_q;
  assign fifo_read  = fifo_read_q;
  assign rd_valid   = rd_valid_q;
  assign owner      = owner_q;
`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt0_d, grant_cnt0_q, grant_cnt1_d, grant_cnt1_q, stall_cnt_d, stall_cnt_q;
  // saturating grant and full-stall counters
  always_comb begin
    grant_cnt0_d = (ack0 & ~&grant_cnt0_q) ? grant_cnt0_q + STAT_W'(1) : grant_cnt0_q;
    grant_cnt1_d = (ack1 & ~&grant_cnt1_q) ? grant_cnt1_q + STAT_W'(1) : grant_cnt1_q;
    stall_cnt_d  = ((req0 | req1) & full & ~&stall_cnt_q) ? stall_cnt_q + STAT_W'(1) : stall_cnt_q;
  end
  // stats registers
  always_ff @(posedge clock) begin
    grant_cnt0_q <= reset ? '0 : grant_cnt0_d;
    grant_cnt1_q <= reset ? '0 : grant_cnt1_d;
    stall_cnt_q  <= reset ? '0 : stall_cnt_d;
  end
  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign stall_cnt  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: directed self-checking bench for fifo_arbiter
module tb_fifo_arbiter;
  import fifo_arb_pkg::*;
  logic        clock = 0, reset = 1, req0 = 0, req1 = 0, rd_req = 0;
  logic [15:0] data0 = 0, data1 = 0, fifo_in;
  logic        ack0, ack1, rd_ack, rd_valid, fifo_write, fifo_read, full, empty, owner;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  fifo_arbiter dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .rd_req(rd_req), .ack0(ack0), .ack1(ack1), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .fifo_write(fifo_write), .fifo_in(fifo_in), .fifo_read(fifo_read), .full(full),
    .empty(empty), .owner(owner)
`ifdef FIFO_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset;
    reset = 1; req0 = 0; req1 = 0; rd_req = 0;
    tick; tick;
    reset = 0;
    #1;
  endtask
  function automatic logic [31:0] cnt;
    return 32'(dut.u_occ.count_q);
  endfunction
  initial begin
    int ord[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    // reset state, with requests asserted to prove acks are gated
    req0 = 1; rd_req = 1;
    tick; tick;
    chk("rst_ack0", ack0, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_fwr", fifo_write, 0);
    chk("rst_frd", fifo_read, 0);
    chk("rst_fin", fifo_in, 0);
    chk("rst_owner", owner, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rdv", rd_valid, 0);
    do_reset;
    // single producer, data 1..5
    for (int i = 0; i < 5; i++) begin
      req0 = 1; data0 = 16'(i + 1);
      #1;
      chk("sp_ack0", ack0, 1);
      chk("sp_ack1", ack1, 0);
      tick;
      chk("sp_fwr", fifo_write, 1);
      chk("sp_fin", fifo_in, i + 1);
    end
    req0 = 0;
    chk("sp_count", cnt(), 5);
    chk("sp_empty", empty, 0);
    tick;
    chk("sp_fwr_off", fifo_write, 0);
    chk("sp_fin_hold", fifo_in, 5);
    // contention: 4 accepts each, req0 first
    do_reset;
    req0 = 1; req1 = 1; data0 = 16'hA000; data1 = 16'hB000;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("ct_ack0", ack0, ord[i] == 0);
      chk("ct_ack1", ack1, ord[i] == 1);
      tick;
      chk("ct_owner", owner, ord[i]);
      chk("ct_fin", fifo_in, ord[i] ? 16'hB000 : 16'hA000);
    end
    chk("ct_count", cnt(), 9);
    // fill to full with producer 0 only
    req1 = 0;
    for (int i = 0; i < 7; i++) tick;
    chk("fl_count", cnt(), 16);
    chk("fl_full", full, 1);
    req1 = 1;
    #1;
    chk("fl_ack0", ack0, 0);
    chk("fl_ack1", ack1, 0);
    rd_req = 1;
    #1;
    chk("fl_rd_ack", rd_ack, 1);
    chk("fl_ack0_rd", ack0, 0);
    tick;
    chk("fl_count15", cnt(), 15);
    chk("fl_full_off", full, 0);
    chk("fl_frd", fifo_read, 1);
    chk("fl_fwr_off", fifo_write, 0);
    rd_req = 0; req1 = 0;
    #1;
    chk("fl_resume", ack0, 1);
    tick;
    chk("fl_refull", full, 1);
    // empty boundary
    do_reset;
    rd_req = 1; req1 = 1; data1 = 16'h1234;
    #1;
    chk("eb_rd_ack0", rd_ack, 0);
    chk("eb_ack1", ack1, 1);
    tick;
    chk("eb_count1", cnt(), 1);
    req1 = 0;
    #1;
    chk("eb_rd_ack1", rd_ack, 1);
    tick;
    rd_req = 0;
    chk("eb_frd", fifo_read, 1);
    chk("eb_rdv0", rd_valid, 0);
    chk("eb_fin", fifo_in, 16'h1234);
    tick;
    chk("eb_rdv1", rd_valid, 1);
    chk("eb_empty", empty, 1);
    // steady stream at count 8
    req0 = 1; data0 = 16'h0055;
    for (int i = 0; i < 8; i++) tick;
    chk("ss_count8", cnt(), 8);
    rd_req = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("ss_ack0", ack0, 1);
      chk("ss_rd_ack", rd_ack, 1);
      tick;
      chk("ss_fwr", fifo_write, 1);
      chk("ss_frd", fifo_read, 1);
      chk("ss_count", cnt(), 8);
    end
    rd_req = 0;
    // reset mid-burst
    req1 = 1;
    tick; tick;
    reset = 1;
    #1;
    chk("rm_ack0", ack0, 0);
    chk("rm_ack1", ack1, 0);
    tick;
    chk("rm_fwr", fifo_write, 0);
    chk("rm_frd", fifo_read, 0);
    chk("rm_count", cnt(), 0);
    chk("rm_state", 32'(dut.state_q), 32'(IDLE));
    chk("rm_empty", empty, 1);
    chk("rm_owner", owner, 0);
`ifdef FIFO_ARB_STATS_EN
    chk("rm_gc0", grant_cnt0, 0);
    chk("rm_gc1", grant_cnt1, 0);
    chk("rm_stall", stall_cnt, 0);
`endif
    reset = 0;
    #1;
    chk("rm_tie0", ack0, 1);
    chk("rm_tie1", ack1, 0);
    tick;
    chk("rm_owner0", owner, 0);
    req0 = 0; req1 = 0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
